mvm_host_seq: RTL and testbench

Synthesizable host-side sequencer that drives the serial load/start/done protocol of the `mvm` matrix-vector multiply cores. It reads matrix A (K×K) and vector x (K) from a local source RAM, streams them into the core, pulses start, waits for done and writes the K results to a result RAM. It replaces bench-driven stimulus so MVM cores can be exercised on-chip or inside larger datapaths.

---
 rtl/mvm_host_seq.sv | 128 ++++++++++++
 tb/tb_mvm_host_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_host_seq.sv
// mvm_host_seq: drives the mvm core's serial load/start/done protocol, streaming
// A and x from a source RAM into the core and writing the K results to a result RAM.
module mvm_host_seq #(
   parameter int K       = 8,
   parameter int B       = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_go,
   input  logic                     cmd_vec_first,
   input  logic                     cmd_abort,
   output logic                     cmd_busy,
   output logic                     cmd_done,
   output logic                     cmd_err,
   output logic [$clog2(K*K+K)-1:0] src_addr,
   input  logic [B-1:0]             src_rdata,
   output logic                     res_we,
   output logic [$clog2(K)-1:0]     res_addr,
   output logic [2*B-1:0]           res_data,
   output logic                     mvm_load_matrix,
   output logic                     mvm_load_vector,
   output logic                     mvm_start,
   output logic [B-1:0]             mvm_data_in,
   input  logic                     mvm_done,
   input  logic [2*B-1:0]           mvm_data_out
);

   localparam int SAW  = $clog2(K*K+K);
   localparam int RAW  = $clog2(K);
   localparam int CMAX = (K*K > TIMEOUT) ? K*K : TIMEOUT;
   localparam int CW   = $clog2(CMAX+1);

   localparam logic [CW-1:0]  LEN_A  = CW'(K*K);
   localparam logic [CW-1:0]  LEN_X  = CW'(K);
   localparam logic [CW-1:0]  T_LAST = CW'(TIMEOUT-1);
   localparam logic [SAW-1:0] BASE_X = SAW'(K*K);

   typedef enum logic [3:0] {
      IDLE, LOAD1, GAP1, LOAD2, GAP2, START, WAIT_DONE, CAPTURE, FINISH
   } state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic          vec_first;
   logic          done_q;

   logic          in_load, load_is_x, done_rise, accept, capture, timeout;
   logic [CW-1:0] load_len;

   assign in_load   = (state == LOAD1) || (state == LOAD2);
   // LOAD1 carries x only when vec_first was latched with the accepted command.
   assign load_is_x = (state == LOAD1) ? vec_first : !vec_first;
   assign load_len  = load_is_x ? LEN_X : LEN_A;
   assign done_rise = mvm_done && !done_q;
   assign accept    = (state == IDLE) && cmd_go && !cmd_abort;
   assign capture   = (state == CAPTURE) && (cnt < LEN_X) && !cmd_abort;
   assign timeout   = (state == WAIT_DONE) && !cmd_abort && !done_rise && (cnt == T_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves next_state
      // unassigned and infers a latch.
      next_state = state;
      if (cmd_abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:      if (cmd_go) next_state = LOAD1;
            LOAD1:     if (cnt == load_len) next_state = GAP1;
            GAP1:      next_state = LOAD2;
            LOAD2:     if (cnt == load_len) next_state = GAP2;
            GAP2:      next_state = START;
            START:     next_state = WAIT_DONE;
            WAIT_DONE: if (done_rise) next_state = CAPTURE;
                       else if (cnt == T_LAST) next_state = IDLE;
            CAPTURE:   if (cnt == LEN_X) next_state = FINISH;
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      cmd_busy        = (state != IDLE);
      cmd_done        = (state == FINISH);
      mvm_start       = (state == START);
      mvm_load_matrix = in_load && (cnt == '0) && !load_is_x;
      mvm_load_vector = in_load && (cnt == '0) && load_is_x;
      mvm_data_in     = '0;
      src_addr        = '0;
      if (in_load && (cnt != '0)) mvm_data_in = src_rdata;
      // Address for word n goes out one cycle ahead of the word itself.
      if (in_load && (cnt < load_len)) src_addr = (load_is_x ? BASE_X : '0) + SAW'(cnt);
   end

   // cnt restarts on every state change and measures time spent in the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         vec_first <= 1'b0;
         done_q    <= 1'b0;
         cmd_err   <= 1'b0;
         res_we    <= 1'b0;
         res_addr  <= '0;
         res_data  <= '0;
      end else begin
         done_q <= mvm_done;
         if ((next_state != state) || (state == IDLE)) cnt <= '0;
         else                                          cnt <= cnt + CW'(1);
         if (accept)       vec_first <= cmd_vec_first;
         if (accept)       cmd_err   <= 1'b0;
         else if (timeout) cmd_err   <= 1'b1;
         res_we <= capture;
         if (capture) begin
            res_addr <= RAW'(cnt);
            res_data <= mvm_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mvm_host_seq.sv
// Bench for mvm_host_seq: source RAM, behavioural mvm core, and a cycle-timeline
// reference of the host protocol with results computed as A*x from the RAM.
module tb_mvm_host_seq;

   localparam int K       = 8;
   localparam int B       = 8;
   localparam int TIMEOUT = 64;
   localparam int SAW     = $clog2(K*K+K);
   localparam int RAW     = $clog2(K);
   localparam int NA      = K*K;
   localparam int S       = K*K+K+5;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           cmd_go = 1'b0, cmd_vec_first = 1'b0, cmd_abort = 1'b0;
   logic           cmd_busy, cmd_done, cmd_err;
   logic [SAW-1:0] src_addr;
   logic [B-1:0]   src_rdata;
   logic           res_we;
   logic [RAW-1:0] res_addr;
   logic [2*B-1:0] res_data;
   logic           mvm_load_matrix, mvm_load_vector, mvm_start;
   logic [B-1:0]   mvm_data_in;
   logic           mvm_done;
   logic [2*B-1:0] mvm_data_out = '0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mvm_host_seq #(.K(K), .B(B), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_go(cmd_go), .cmd_vec_first(cmd_vec_first), .cmd_abort(cmd_abort),
      .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
      .src_addr(src_addr), .src_rdata(src_rdata),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
      .mvm_load_matrix(mvm_load_matrix), .mvm_load_vector(mvm_load_vector),
      .mvm_start(mvm_start), .mvm_data_in(mvm_data_in),
      .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
   );

   // Source RAM with one cycle of read latency.
   logic [B-1:0] ram [K*K+K];
   always @(posedge clk) src_rdata <= ram[src_addr];

   // Behavioural core: captures the streams, answers A*x core_lat cycles after start.
   logic           core_done = 1'b0;
   bit             core_never = 1'b0;
   int             core_lat = 4;
   bit             ovr_en = 1'b0, ovr_val = 1'b0;
   int             c_load = 0, c_idx = 0, c_phase = 0, c_wait = 0, c_out = 0;
   logic [B-1:0]   c_a [K*K];
   logic [B-1:0]   c_x [K];
   logic [2*B-1:0] c_y [K];

   assign mvm_done = ovr_en ? ovr_val : core_done;

   function automatic logic [2*B-1:0] core_row(input int i);
      int acc = 0;
      for (int j = 0; j < K; j++) acc += $signed(c_a[i*K+j]) * $signed(c_x[j]);
      return acc[2*B-1:0];
   endfunction

   always @(posedge clk) begin
      if (mvm_load_matrix) begin
         c_load <= 1; c_idx <= 0;
      end else if (mvm_load_vector) begin
         c_load <= 2; c_idx <= 0;
      end else if (c_load == 1) begin
         c_a[c_idx] <= mvm_data_in; c_idx <= c_idx + 1;
         if (c_idx == K*K-1) c_load <= 0;
      end else if (c_load == 2) begin
         c_x[c_idx] <= mvm_data_in; c_idx <= c_idx + 1;
         if (c_idx == K-1) c_load <= 0;
      end
      if (mvm_start && !core_never) begin
         for (int i = 0; i < K; i++) c_y[i] <= core_row(i);
         c_phase <= 1; c_wait <= core_lat - 2;
      end else if (c_phase == 1) begin
         if (c_wait == 0) begin
            core_done <= 1'b1; c_phase <= 2; c_out <= 0;
            mvm_data_out <= 16'($urandom);
         end else begin
            c_wait <= c_wait - 1;
         end
      end else if (c_phase == 2) begin
         if (c_out == K) begin
            core_done <= 1'b0; c_phase <= 0; mvm_data_out <= 16'($urandom);
         end else begin
            mvm_data_out <= c_y[c_out]; c_out <= c_out + 1;
         end
      end
   end

   // Reference timeline of one command, relative to the cmd_go cycle 0.
   typedef struct packed {
      logic           busy, done, err, lm, lv, st, we;
      logic [RAW-1:0] ra;
      logic [2*B-1:0] rd;
      logic [B-1:0]   din;
   } obs_t;

   bit             r_vf, r_timeout, err_prev = 1'b0;
   int             r_lat, r_abort, r_reset;
   logic [2*B-1:0] exp_y [K];
   logic [2*B-1:0] res_seen [K];
   int             done_cnt, we_cnt;

   function automatic logic [2*B-1:0] ref_row(input int i);
      int acc = 0;
      for (int j = 0; j < K; j++) acc += $signed(ram[i*K+j]) * $signed(ram[NA+j]);
      return acc[2*B-1:0];
   endfunction

   function automatic obs_t expect_at(input int c);
      obs_t e;
      int   pa, px, d, busy_end;
      e  = '0;
      pa = r_vf ? K+3 : 1;
      px = r_vf ? 1 : NA+3;
      d  = S + r_lat;
      busy_end = r_timeout ? S + TIMEOUT : d + K + 2;
      if (c == 0) begin
         e.err = err_prev;
         return e;
      end
      if (r_reset >= 0 && c > r_reset) return e;
      if (r_abort >= 0 && c > r_abort) return e;
      e.busy = (c <= busy_end);
      e.err  = r_timeout && (c > S + TIMEOUT);
      e.lm   = (c == pa);
      e.lv   = (c == px);
      e.st   = (c == S);
      if (c > pa && c <= pa + NA) e.din = ram[c-pa-1];
      if (c > px && c <= px + K)  e.din = ram[NA+c-px-1];
      if (!r_timeout && c >= d+2 && c <= d+K+1) begin
         e.we = 1'b1;
         e.ra = RAW'(c-d-2);
         e.rd = exp_y[c-d-2];
      end
      e.done = !r_timeout && (c == d+K+2);
      return e;
   endfunction

   function automatic obs_t observe(input logic exp_we);
      obs_t o;
      o.busy = cmd_busy;        o.done = cmd_done;        o.err = cmd_err;
      o.lm   = mvm_load_matrix; o.lv   = mvm_load_vector; o.st  = mvm_start;
      o.we   = res_we;
      o.ra   = exp_we ? res_addr : '0;
      o.rd   = exp_we ? res_data : '0;
      o.din  = mvm_data_in;
      return o;
   endfunction

   task automatic run_cmd(input bit vf, input int lat, input int abort_at, input int reset_at,
                          input bit tmo, input int ovr_rel, input bit busy_go);
      obs_t e, o;
      int   end_c, d, pa, px;
      logic [SAW-1:0] exp_a;
      r_vf = vf; r_lat = lat; r_abort = abort_at; r_reset = reset_at; r_timeout = tmo;
      core_lat = lat; core_never = tmo;
      for (int i = 0; i < K; i++) begin
         exp_y[i] = ref_row(i);
         res_seen[i] = 16'hdead;
      end
      done_cnt = 0; we_cnt = 0;
      d  = S + lat;
      pa = vf ? K+3 : 1;
      px = vf ? 1 : NA+3;
      if (tmo)                end_c = S + TIMEOUT + 3;
      else if (abort_at >= 0) end_c = abort_at + 4;
      else if (reset_at >= 0) end_c = reset_at + 4;
      else                    end_c = d + K + 4;
      for (int c = 0; c <= end_c; c++) begin
         e = expect_at(c);
         o = observe(e.we);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL timeline cycle %0d: got %h, expected %h", c, o, e);
         end
         if ((abort_at < 0 || c <= abort_at) && (reset_at < 0 || c <= reset_at) &&
             ((c >= pa && c < pa + NA) || (c >= px && c < px + K))) begin
            exp_a = (c >= pa && c < pa + NA) ? SAW'(c - pa) : SAW'(NA + c - px);
            vectors++;
            if (src_addr !== exp_a) begin
               miscompares++;
               $display("FAIL src_addr cycle %0d: got %0d, expected %0d", c, src_addr, exp_a);
            end
         end
         if (res_we === 1'b1) begin
            we_cnt++;
            res_seen[res_addr] = res_data;
         end
         if (cmd_done === 1'b1) done_cnt++;
         cmd_go        = (c == 0) || (busy_go && (c == 5 || c == S || c == d+3 || c == d+K+2));
         cmd_vec_first = (c == 0) ? vf : ~vf;
         cmd_abort     = (c == abort_at);
         if (c == ovr_rel) ovr_en = 1'b0;
         if (reset_at >= 0 && c == reset_at + 1) reset = 1'b1;
         if (reset_at >= 0 && c == reset_at) begin
            reset = 1'b0;
            #1;
            vectors++;
            if ({cmd_busy, cmd_done, cmd_err, src_addr, res_we, res_addr, res_data,
                 mvm_load_matrix, mvm_load_vector, mvm_start, mvm_data_in} !== '0) begin
               miscompares++;
               $display("FAIL async_reset cycle %0d: outputs not all zero (we=%b busy=%b)",
                        c, res_we, cmd_busy);
            end
         end
         @(posedge clk);
         #1;
      end
      cmd_go = 1'b0; cmd_abort = 1'b0;
      err_prev = expect_at(end_c).err;
   endtask

   task automatic fill_random();
      for (int i = 0; i < K*K+K; i++) ram[i] = B'($urandom);
   endtask

   task automatic check_results(input string name);
      vectors++;
      if (done_cnt != 1 || we_cnt != K) begin
         miscompares++;
         $display("FAIL %s pulses: got done=%0d writes=%0d, expected done=1 writes=%0d",
                  name, done_cnt, we_cnt, K);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({cmd_busy, cmd_done, cmd_err, src_addr, res_we, res_addr, res_data,
           mvm_load_matrix, mvm_load_vector, mvm_start, mvm_data_in} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: outputs not all zero (busy=%b err=%b)", cmd_busy, cmd_err);
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (cmd_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_busy: got %b, expected 0", cmd_busy);
      end
   endtask

   task automatic load_identity();
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++) ram[i*K+j] = (i == j) ? 8'd1 : 8'd0;
      for (int j = 0; j < K; j++) ram[NA+j] = B'(j + 1);
   endtask

   task automatic test_identity(input bit vf);
      load_identity();
      run_cmd(vf, 2 + int'($urandom_range(0, 8)), -1, -1, 1'b0, -1, 1'b0);
      for (int i = 0; i < K; i++) begin
         vectors++;
         if (res_seen[i] !== 16'(i + 1)) begin
            miscompares++;
            $display("FAIL identity vf=%0d res[%0d]: got %h, expected %h", vf, i, res_seen[i], 16'(i + 1));
         end
      end
      check_results("identity");
   endtask

   task automatic test_random();
      for (int n = 0; n < 3; n++) begin
         fill_random();
         run_cmd(1'($urandom), 2 + int'($urandom_range(0, 10)), -1, -1, 1'b0, -1, 1'b0);
         check_results("random");
      end
   endtask

   task automatic test_timeout();
      fill_random();
      run_cmd(1'b0, 2, -1, -1, 1'b1, -1, 1'b0);
      vectors++;
      if (cmd_err !== 1'b1 || we_cnt != 0 || done_cnt != 0) begin
         miscompares++;
         $display("FAIL timeout: got err=%b writes=%0d done=%0d, expected err=1 writes=0 done=0",
                  cmd_err, we_cnt, done_cnt);
      end
      run_cmd(1'b1, 3, -1, -1, 1'b0, -1, 1'b0);
      check_results("after_timeout");
   endtask

   task automatic test_abort();
      fill_random();
      run_cmd(1'b0, 4, 40, -1, 1'b0, -1, 1'b0);
      cmd_go = 1'b1; cmd_abort = 1'b1;
      @(posedge clk);
      #1;
      cmd_go = 1'b0; cmd_abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (cmd_busy !== 1'b0 || mvm_load_matrix !== 1'b0 || mvm_load_vector !== 1'b0) begin
            miscompares++;
            $display("FAIL go_with_abort: got busy=%b, expected 0", cmd_busy);
         end
         @(posedge clk);
         #1;
      end
      run_cmd(1'b0, 5, -1, -1, 1'b0, -1, 1'b0);
      check_results("after_abort");
   endtask

   task automatic test_reset_capture();
      fill_random();
      run_cmd(1'b0, 5, -1, S + 5 + 4, 1'b0, -1, 1'b0);
      vectors++;
      if (we_cnt != 3 || done_cnt != 0) begin
         miscompares++;
         $display("FAIL reset_capture: got writes=%0d done=%0d, expected writes=3 done=0", we_cnt, done_cnt);
      end
      ovr_en = 1'b1; ovr_val = 1'b1;
      run_cmd(1'b1, 30, -1, -1, 1'b0, 100, 1'b0);
      check_results("done_held_high");
      ovr_val = 1'b0;
   endtask

   task automatic test_negative();
      for (int i = 0; i < NA; i++) ram[i] = 8'hff;
      for (int j = 0; j < K; j++) ram[NA+j] = 8'h80;
      run_cmd(1'b0, 6, -1, -1, 1'b0, -1, 1'b1);
      for (int i = 0; i < K; i++) begin
         vectors++;
         if (res_seen[i] !== 16'h0400) begin
            miscompares++;
            $display("FAIL negative res[%0d]: got %h, expected 0400", i, res_seen[i]);
         end
      end
      check_results("negative");
   endtask

   initial begin
      for (int i = 0; i < K*K+K; i++) ram[i] = '0;
      test_reset();
      test_identity(1'b0);
      test_identity(1'b1);
      test_random();
      test_timeout();
      test_abort();
      test_reset_capture();
      test_negative();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
